// File: rtl/rv32imf_apu_result_buffer_if.sv
// Bundle between the APU response side, the EX-stage writeback mux and the
// decode-stage dependency check for the APU result buffer.
interface rv32imf_apu_result_buffer_if #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned FLAGS_W = 5,
    parameter int unsigned NUM_RD  = 3
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     apu_rvalid_i;
    logic [DATA_W-1:0]        apu_result_i;
    logic [ADDR_W-1:0]        apu_waddr_i;
    logic [FLAGS_W-1:0]       apu_flags_i;
    logic                     wb_block_i;
    logic                     wb_valid_o;
    logic [ADDR_W-1:0]        wb_waddr_o;
    logic [DATA_W-1:0]        wb_wdata_o;
    logic                     fflags_we_o;
    logic [FLAGS_W-1:0]       fflags_o;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD-1:0]        rd_valid_i;
    logic                     rd_dep_o;
    logic [CNT_W-1:0]         count_o;
    logic                     full_o;
    logic                     busy_o;
    logic                     overflow_o;

    modport master (
        output apu_rvalid_i, apu_result_i, apu_waddr_i, apu_flags_i, wb_block_i,
               rd_addr_i, rd_valid_i,
        input  wb_valid_o, wb_waddr_o, wb_wdata_o, fflags_we_o, fflags_o, rd_dep_o,
               count_o, full_o, busy_o, overflow_o
    );

    modport slave (
        input  apu_rvalid_i, apu_result_i, apu_waddr_i, apu_flags_i, wb_block_i,
               rd_addr_i, rd_valid_i,
        output wb_valid_o, wb_waddr_o, wb_wdata_o, fflags_we_o, fflags_o, rd_dep_o,
               count_o, full_o, busy_o, overflow_o
    );
endinterface

// File: rtl/rv32imf_apu_result_buffer.sv
// In-order FIFO holding APU/FPU results while the writeback port is blocked,
// with zero-latency bypass when empty, sticky overflow and pending-write dependency check.
module rv32imf_apu_result_buffer #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned FLAGS_W = 5,
    parameter int unsigned NUM_RD  = 3
) (
    input logic                         clk,
    input logic                         rst_n,
    rv32imf_apu_result_buffer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [ADDR_W-1:0]  addr_q  [DEPTH];
    logic [FLAGS_W-1:0] flags_q [DEPTH];
    logic [DEPTH-1:0]   occ_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic busy, full, push_req, push, pop, drop, wb_valid, rd_dep;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign busy     = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    // Anything arriving behind buffered entries must queue to keep program order.
    assign push_req = bus.apu_rvalid_i & (bus.wb_block_i | busy);
    assign pop      = busy & ~bus.wb_block_i;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign wb_valid = rst_n & ~bus.wb_block_i & (busy | bus.apu_rvalid_i);

    always_comb begin
        rd_dep = 1'b0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (occ_q[j] && bus.rd_valid_i[i] &&
                    (bus.rd_addr_i[i*ADDR_W +: ADDR_W] == addr_q[j])) begin
                    rd_dep = 1'b1;
                end
            end
        end
    end

    assign bus.wb_valid_o  = wb_valid;
    assign bus.fflags_we_o = wb_valid;
    assign bus.wb_waddr_o  = busy ? addr_q[rd_ptr_q]  : bus.apu_waddr_i;
    assign bus.wb_wdata_o  = busy ? data_q[rd_ptr_q]  : bus.apu_result_i;
    assign bus.fflags_o    = busy ? flags_q[rd_ptr_q] : bus.apu_flags_i;
    assign bus.rd_dep_o    = rd_dep;
    assign bus.count_o     = count_q;
    assign bus.full_o      = full;
    assign bus.busy_o      = busy;
    assign bus.overflow_o  = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            occ_q      <= '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                data_q[j]  <= '0;
                addr_q[j]  <= '0;
                flags_q[j] <= '0;
            end
        end else begin
            if (pop) begin
                rd_ptr_q        <= next_ptr(rd_ptr_q);
                occ_q[rd_ptr_q] <= 1'b0;
            end
            // When full, the freed slot and the write slot coincide; the set wins.
            if (push) begin
                wr_ptr_q          <= next_ptr(wr_ptr_q);
                occ_q[wr_ptr_q]   <= 1'b1;
                data_q[wr_ptr_q]  <= bus.apu_result_i;
                addr_q[wr_ptr_q]  <= bus.apu_waddr_i;
                flags_q[wr_ptr_q] <= bus.apu_flags_i;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rv32imf_apu_result_buffer.sv
// Bench for the APU result buffer: DEPTH=2 and DEPTH=3 instances share stimulus and are
// checked every cycle against a queue model, plus hand-computed literal expectations.
module tb_rv32imf_apu_result_buffer;
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
        logic [4:0]  f;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv = 1'b0;
    logic [5:0]  wa = '0;
    logic [31:0] wd = '0;
    logic [4:0]  wf = '0;
    logic        blk = 1'b0;
    logic [17:0] rda = '0;
    logic [2:0]  rdv = '0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv32imf_apu_result_buffer_if #(.DEPTH(2)) if0 ();
    rv32imf_apu_result_buffer_if #(.DEPTH(3)) if1 ();

    assign if0.apu_rvalid_i = rv;
    assign if0.apu_result_i = wd;
    assign if0.apu_waddr_i  = wa;
    assign if0.apu_flags_i  = wf;
    assign if0.wb_block_i   = blk;
    assign if0.rd_addr_i    = rda;
    assign if0.rd_valid_i   = rdv;
    assign if1.apu_rvalid_i = rv;
    assign if1.apu_result_i = wd;
    assign if1.apu_waddr_i  = wa;
    assign if1.apu_flags_i  = wf;
    assign if1.wb_block_i   = blk;
    assign if1.rd_addr_i    = rda;
    assign if1.rd_valid_i   = rdv;

    rv32imf_apu_result_buffer #(.DEPTH(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    rv32imf_apu_result_buffer #(.DEPTH(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [1:0]  o_valid, o_fwe, o_dep, o_full, o_busy, o_ovf;
    logic [5:0]  o_addr  [2];
    logic [31:0] o_data  [2];
    logic [4:0]  o_flags [2];
    logic [1:0]  o_cnt   [2];

    assign o_valid = {if1.wb_valid_o, if0.wb_valid_o};
    assign o_fwe   = {if1.fflags_we_o, if0.fflags_we_o};
    assign o_dep   = {if1.rd_dep_o, if0.rd_dep_o};
    assign o_full  = {if1.full_o, if0.full_o};
    assign o_busy  = {if1.busy_o, if0.busy_o};
    assign o_ovf   = {if1.overflow_o, if0.overflow_o};
    assign o_addr[0]  = if0.wb_waddr_o;
    assign o_addr[1]  = if1.wb_waddr_o;
    assign o_data[0]  = if0.wb_wdata_o;
    assign o_data[1]  = if1.wb_wdata_o;
    assign o_flags[0] = if0.fflags_o;
    assign o_flags[1] = if1.fflags_o;
    assign o_cnt[0]   = if0.count_o;
    assign o_cnt[1]   = if1.count_o;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded in-order queue per instance.
    ent_t mq [2][$];
    logic movf [2] = '{1'b0, 1'b0};
    ent_t h;
    logic ev, eb, edep;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                check($sformatf("d%0d_rst_valid", k), 32'(o_valid[k]), 32'd0);
                check($sformatf("d%0d_rst_count", k), 32'(o_cnt[k]), 32'd0);
                check($sformatf("d%0d_rst_busy", k), 32'(o_busy[k]), 32'd0);
                check($sformatf("d%0d_rst_ovf", k), 32'(o_ovf[k]), 32'd0);
                check($sformatf("d%0d_rst_dep", k), 32'(o_dep[k]), 32'd0);
                mq[k].delete();
                movf[k] = 1'b0;
            end else begin
                eb = (mq[k].size() != 0);
                ev = !blk && (eb || rv);
                check($sformatf("d%0d_valid", k), 32'(o_valid[k]), 32'(ev));
                check($sformatf("d%0d_fflags_we", k), 32'(o_fwe[k]), 32'(ev));
                if (ev) begin
                    if (eb) h = mq[k][0];
                    else begin
                        h.a = wa; h.d = wd; h.f = wf;
                    end
                    check($sformatf("d%0d_waddr", k), 32'(o_addr[k]), 32'(h.a));
                    check($sformatf("d%0d_wdata", k), o_data[k], h.d);
                    check($sformatf("d%0d_fflags", k), 32'(o_flags[k]), 32'(h.f));
                end
                check($sformatf("d%0d_count", k), 32'(o_cnt[k]), 32'(mq[k].size()));
                check($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(eb));
                check($sformatf("d%0d_full", k), 32'(o_full[k]), 32'(mq[k].size() == k + 2));
                check($sformatf("d%0d_ovf", k), 32'(o_ovf[k]), 32'(movf[k]));
                edep = 1'b0;
                for (int i = 0; i < 3; i++)
                    for (int e = 0; e < mq[k].size(); e++)
                        if (rdv[i] && rda[i*6 +: 6] == mq[k][e].a) edep = 1'b1;
                check($sformatf("d%0d_dep", k), 32'(o_dep[k]), 32'(edep));
                // State after the coming rising edge.
                if (eb && !blk) void'(mq[k].pop_front());
                if (rv && (blk || eb)) begin
                    h.a = wa; h.d = wd; h.f = wf;
                    if (mq[k].size() < k + 2) mq[k].push_back(h);
                    else movf[k] = 1'b1;
                end
            end
        end
    end

    logic [1:0] seen9 = '0;
    always @(negedge clk) begin
        if (if0.wb_valid_o && if0.wb_waddr_o == 6'd9) seen9[0] <= 1'b1;
        if (if1.wb_valid_o && if1.wb_waddr_o == 6'd9) seen9[1] <= 1'b1;
    end

    task automatic cyc(input logic r, input logic [5:0] a, input logic b,
                       input logic [2:0] v, input logic [5:0] ra);
        @(posedge clk);
        #1;
        rv = r; wa = a; blk = b; rdv = v;
        wd = {26'h28D_0000, a} ^ 32'h0000_1200;
        wf = a[4:0] ^ 5'h15;
        rda = {ra, 6'd63, 6'd62};
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_count", 32'(if0.count_o), 32'd0);
        check("reset_valid", 32'(if1.wb_valid_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass: empty, unblocked, same-cycle presentation, bypass excluded from dep.
        cyc(1'b1, 6'd5, 1'b0, 3'b100, 6'd5);
        wd = 32'h3F80_0000;
        #1;
        check("t1_valid", 32'(if0.wb_valid_o), 32'd1);
        check("t1_waddr", 32'(if0.wb_waddr_o), 32'd5);
        check("t1_wdata", if0.wb_wdata_o, 32'h3F80_0000);
        check("t1_dep", 32'(if0.rd_dep_o), 32'd0);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t1_count", 32'(if0.count_o), 32'd0);

        // Hold for three blocked cycles.
        cyc(1'b1, 6'd7, 1'b1, 3'b000, 6'd0);
        cyc(1'b0, 6'd0, 1'b1, 3'b100, 6'd7);
        check("t2_count", 32'(if0.count_o), 32'd1);
        check("t2_dep", 32'(if1.rd_dep_o), 32'd1);
        cyc(1'b0, 6'd0, 1'b1, 3'b000, 6'd0);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t2_wb_valid", 32'(if0.wb_valid_o), 32'd1);
        check("t2_wb_waddr", 32'(if0.wb_waddr_o), 32'd7);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t2_count_end", 32'(if0.count_o), 32'd0);

        // Order: C arrives as the port unblocks and must queue behind A and B.
        cyc(1'b1, 6'd1, 1'b1, 3'b000, 6'd0);
        cyc(1'b1, 6'd2, 1'b1, 3'b000, 6'd0);
        cyc(1'b1, 6'd3, 1'b0, 3'b000, 6'd0);
        check("t3_first", 32'(if0.wb_waddr_o), 32'd1);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t3_second", 32'(if1.wb_waddr_o), 32'd2);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t3_third", 32'(if0.wb_waddr_o), 32'd3);
        check("t3_third_valid", 32'(if0.wb_valid_o), 32'd1);

        // Overflow on DEPTH=2; DEPTH=3 still has room.
        cyc(1'b1, 6'd10, 1'b1, 3'b000, 6'd0);
        cyc(1'b1, 6'd11, 1'b1, 3'b000, 6'd0);
        cyc(1'b1, 6'd9, 1'b1, 3'b000, 6'd0);
        check("t4_full_before", 32'(if0.full_o), 32'd1);
        cyc(1'b0, 6'd0, 1'b1, 3'b000, 6'd0);
        check("t4_ovf0", 32'(if0.overflow_o), 32'd1);
        check("t4_count0", 32'(if0.count_o), 32'd2);
        check("t4_ovf1", 32'(if1.overflow_o), 32'd0);
        check("t4_count1", 32'(if1.count_o), 32'd3);
        for (int i = 0; i < 4; i++) cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t4_no9_d0", 32'(seen9[0]), 32'd0);
        check("t4_9_d1", 32'(seen9[1]), 32'd1);
        check("t4_sticky", 32'(if0.overflow_o), 32'd1);

        // Wrap: continuous arrivals with a toggling block pattern.
        for (int i = 0; i < 10; i++) cyc(1'b1, 6'(20 + i), (i % 3) != 2, 3'b111, 6'(20 + i));
        for (int i = 0; i < 6; i++) cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t5_count0", 32'(if0.count_o), 32'd0);
        check("t5_count1", 32'(if1.count_o), 32'd0);

        // Reset mid-operation.
        cyc(1'b1, 6'd30, 1'b1, 3'b000, 6'd0);
        cyc(1'b1, 6'd31, 1'b1, 3'b000, 6'd0);
        cyc(1'b0, 6'd0, 1'b1, 3'b000, 6'd0);
        check("t6_count_pre", 32'(if1.count_o), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0; rv = 1'b1; wa = 6'd40; blk = 1'b0;
        #1;
        check("t6_valid", 32'(if0.wb_valid_o), 32'd0);
        check("t6_count", 32'(if1.count_o), 32'd0);
        check("t6_ovf", 32'(if0.overflow_o), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 6'd41, 1'b0, 3'b000, 6'd0);
        check("t6_bypass_valid", 32'(if0.wb_valid_o), 32'd1);
        check("t6_bypass_waddr", 32'(if1.wb_waddr_o), 32'd41);
        cyc(1'b0, 6'd0, 1'b0, 3'b000, 6'd0);
        check("t6_count_end", 32'(if0.count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
